spike_packet_fifo: RTL

SPIKE_PACKET_FIFO -- requirements
Module: spike_packet_fifo

---
 rtl/spike_packet_fifo_pkg.sv | 9 +
 rtl/spike_packet_fifo_if.sv | 34 +++
 rtl/spike_fifo_mem.sv | 24 ++
 rtl/spike_packet_fifo.sv | 75 +++++++
 4 files changed

// File: rtl/spike_packet_fifo_pkg.sv
// Spike packet FIFO: shared widths.
// Default packet width and occupancy counter width.
package spike_packet_fifo_pkg;

  localparam int SPIKE_DW    = 30;
  localparam int SPIKE_DEPTH = 4;
  localparam int SPIKE_CW    = $clog2(SPIKE_DEPTH + 1);

endpackage

// File: rtl/spike_packet_fifo_if.sv
// Spike packet FIFO: producer/consumer bus.
// The FIFO is the slave; the master drives packets and stall.
interface spike_packet_fifo_if
  import spike_packet_fifo_pkg::*;
#(
  parameter int DW = SPIKE_DW
);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          out_stall;
  logic [DW-1:0] out_data;
  logic          out_en;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output out_stall,
    input  out_data,
    input  out_en
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  out_stall,
    output out_data,
    output out_en
  );

endinterface

// File: rtl/spike_fifo_mem.sv
// Spike packet FIFO: storage array.
// Written on push, read asynchronously; contents survive reset.
module spike_fifo_mem #(
  parameter int DW    = 30,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spike_packet_fifo.sv
// Spike packet FIFO: pointers, occupancy, output register.
// Registered pop output; no bypass, so an empty FIFO adds a cycle.
module spike_packet_fifo
  import spike_packet_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SPIKE_DW,
  parameter int DEPTH      = SPIKE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  spike_packet_fifo_if.slave         bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] odata;
  logic                  oen;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign full = (cnt == CW'(DEPTH));
  assign push = bus.in_valid && !full && !flush;
  assign pop  = (cnt != '0) && !bus.out_stall && !flush;

  spike_fifo_mem #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (bus.in_data),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      oen   <= 1'b0;
      odata <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      oen  <= 1'b0;
    end else begin
      oen <= pop;
      if (pop) begin
        odata <= rdata;
        rptr  <= rptr + 1'b1;
      end
      if (push) wptr <= wptr + 1'b1;
      // Push and pop together leave occupancy unchanged.
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  assign bus.in_ready = !full;
  assign bus.out_data = odata;
  assign bus.out_en   = oen;
  assign count        = cnt;

endmodule
